// File: rtl/pll_sequencer_if.sv
// pll_sequencer_if: divider request channel between the host and the PLL sequencer.
// Latency: none; this interface only carries wires.
// Backpressure: the host holds cfg_valid and the divider values until it sees cfg_ready.
`timescale 1ns/1ps

interface pll_sequencer_if;
  logic       cfg_valid;
  logic [5:0] cfg_fdiv;
  logic [5:0] cfg_idiv;
  logic       cfg_ready;

  modport master (
    output cfg_valid,
    output cfg_fdiv,
    output cfg_idiv,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_fdiv,
    input  cfg_idiv,
    output cfg_ready
  );
endinterface

// File: rtl/pll_sequencer.sv
// pll_sequencer: rPLL reset/lock bring-up with bounded lock retries and divider reconfiguration.
// Latency: pll_lock to lock_s is 2 cycles, +1 to SETTLE, +SETTLE_CYCLES to clk_en; all outputs registered.
// Backpressure: cfg_ready is high only in RUN/FAIL; requests elsewhere wait with cfg_valid held.
`timescale 1ns/1ps

module pll_sequencer #(
  parameter logic [5:0] FDIV_INIT     = 6'd0,
  parameter logic [5:0] IDIV_INIT     = 6'd0,
  parameter int         RESET_CYCLES  = 16,
  parameter int         LOCK_TIMEOUT  = 16000,
  parameter int         SETTLE_CYCLES = 64,
  parameter int         MAX_RETRY     = 3
) (
  input  logic                  clkin,
  input  logic                  reset_n,
  pll_sequencer_if.slave        cfg,
  input  logic                  pll_lock,
  output logic                  pll_reset,
  output logic [5:0]            pll_fdiv,
  output logic [5:0]            pll_idiv,
  output logic                  clk_en,
  output logic                  locked,
  output logic                  err,
  output logic                  lock_lost,
  output logic [3:0]            retry_cnt
);

  // One shared counter serves every timed state, so it is sized for the longest interval.
  localparam int MAX_RL  = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_ALL = (MAX_RL > SETTLE_CYCLES) ? MAX_RL : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RST,
    S_WAIT_LOCK,
    S_SETTLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_lock_meta;
  logic             r_lock_s;
  logic             r_pll_reset;
  logic [5:0]       r_pll_fdiv;
  logic [5:0]       r_pll_idiv;
  logic             r_clk_en;
  logic             r_err;
  logic             r_lock_lost;
  logic             r_cfg_ready;
  logic [3:0]       r_retry_cnt;

  // A request is taken only while the registered ready is high, i.e. in RUN or FAIL.
  logic w_accept;
  assign w_accept = cfg.cfg_valid & r_cfg_ready;

  // Two-flop synchroniser: pll_lock is asynchronous to clkin, only r_lock_s is used below.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= pll_lock;
      r_lock_s    <= r_lock_meta;
    end
  end

  // Sequencer FSM; every output is computed for the state being entered so outputs stay registered.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_RST;
      r_cnt       <= '0;
      r_pll_reset <= 1'b1;
      r_pll_fdiv  <= FDIV_INIT;
      r_pll_idiv  <= IDIV_INIT;
      r_clk_en    <= 1'b0;
      r_err       <= 1'b0;
      r_lock_lost <= 1'b0;
      r_cfg_ready <= 1'b0;
      r_retry_cnt <= 4'd0;
    end else begin
      r_lock_lost <= 1'b0;
      case (r_state)
        // Hold the PLL in reset for RESET_CYCLES edges, then release it.
        S_RST: begin
          if (r_cnt == RST_LAST) begin
            r_state     <= S_WAIT_LOCK;
            r_cnt       <= '0;
            r_pll_reset <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // Wait for synchronised lock; on timeout either retry or give up.
        S_WAIT_LOCK: begin
          if (r_lock_s) begin
            r_state <= S_SETTLE;
            r_cnt   <= '0;
          end else if (r_cnt == TO_LAST) begin
            r_cnt       <= '0;
            r_pll_reset <= 1'b1;
            if (r_retry_cnt < RETRY_MAX) begin
              r_state     <= S_RST;
              r_retry_cnt <= r_retry_cnt + 1'b1;
            end else begin
              r_state     <= S_FAIL;
              r_err       <= 1'b1;
              r_cfg_ready <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // Lock must stay high for SETTLE_CYCLES consecutive cycles; any dip restarts the wait.
        S_SETTLE: begin
          if (!r_lock_s) begin
            r_state <= S_WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == SETTLE_LAST) begin
            r_state     <= S_RUN;
            r_cnt       <= '0;
            r_clk_en    <= 1'b1;
            r_cfg_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // Clocks usable. A request beats a simultaneous lock loss, but the loss still pulses.
        S_RUN: begin
          if (!r_lock_s) begin
            r_lock_lost <= 1'b1;
          end
          if (w_accept || !r_lock_s) begin
            r_state     <= S_RST;
            r_cnt       <= '0;
            r_pll_reset <= 1'b1;
            r_clk_en    <= 1'b0;
            r_cfg_ready <= 1'b0;
            r_retry_cnt <= 4'd0;
            r_err       <= 1'b0;
          end
          // Dividers only move on the edge that also raises pll_reset.
          if (w_accept) begin
            r_pll_fdiv <= cfg.cfg_fdiv;
            r_pll_idiv <= cfg.cfg_idiv;
          end
        end

        // Retries exhausted: PLL stays in reset until the host supplies new dividers.
        S_FAIL: begin
          if (w_accept) begin
            r_state     <= S_RST;
            r_cnt       <= '0;
            r_pll_reset <= 1'b1;
            r_pll_fdiv  <= cfg.cfg_fdiv;
            r_pll_idiv  <= cfg.cfg_idiv;
            r_err       <= 1'b0;
            r_cfg_ready <= 1'b0;
            r_retry_cnt <= 4'd0;
          end
        end

        default: begin
          r_state     <= S_RST;
          r_cnt       <= '0;
          r_pll_reset <= 1'b1;
          r_clk_en    <= 1'b0;
          r_cfg_ready <= 1'b0;
        end
      endcase
    end
  end

  assign pll_reset     = r_pll_reset;
  assign pll_fdiv      = r_pll_fdiv;
  assign pll_idiv      = r_pll_idiv;
  assign clk_en        = r_clk_en;
  assign locked        = r_clk_en;
  assign err           = r_err;
  assign lock_lost     = r_lock_lost;
  assign retry_cnt     = r_retry_cnt;
  assign cfg.cfg_ready = r_cfg_ready;

endmodule
